change_dispenser: RTL and testbench

Sequential coin-return engine for the vending machine. It sits behind the state/total calculator and generates the `o_return_coin` stream that the calculator accumulates into its return total. On a return request it pays out the requested amount greedily, largest coin first, one coin per cycle, limited by a per-coin stock inventory. It reports completion, shortfall, and residual amount when done.

---
 rtl/change_dispenser.sv | 145 ++++++++++++++
 tb/tb_change_dispenser.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy coin-return engine. On a return request it pays out the amount
// one coin per cycle, largest coin first, limited by per-coin stock. At the
// end it pulses o_done and reports shortfall and the unpaid residual.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_return_req        start a payout (taken only in IDLE)
//   i_return_amount     amount to pay, sampled with i_return_req
//   i_input_coin        per-type coin inserted this cycle (adds stock)
//   o_return_coin       registered one-hot coin issued this cycle
//   o_busy              high in DISPENSE and DONE
//   o_done              one-cycle pulse at payout end
//   o_short, o_residual shortfall flag and unpaid amount, valid with o_done
//   o_stock             packed stock counters, coin i at [i*STOCK_BITS +: STOCK_BITS]
module change_dispenser #(
   parameter int unsigned NUM_COINS  = 3,
   parameter int unsigned TOTAL_BITS = 31,
   parameter int unsigned STOCK_BITS = 8,
   parameter int unsigned COIN_VAL0  = 100,
   parameter int unsigned COIN_VAL1  = 500,
   parameter int unsigned COIN_VAL2  = 1000,
   parameter int unsigned INIT_STOCK = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_return_req,
   input  logic [TOTAL_BITS-1:0]           i_return_amount,
   input  logic [NUM_COINS-1:0]            i_input_coin,
   output logic [NUM_COINS-1:0]            o_return_coin,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_short,
   output logic [TOTAL_BITS-1:0]           o_residual,
   output logic [NUM_COINS*STOCK_BITS-1:0] o_stock
);

   typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

   state_t                  state_q;
   logic [TOTAL_BITS-1:0]   remaining_q;
   logic [NUM_COINS-1:0]    ret_q;
   logic                    done_q;
   logic                    short_q;
   logic [TOTAL_BITS-1:0]   residual_q;
   logic [STOCK_BITS-1:0]   stock_q [NUM_COINS];
   logic [STOCK_BITS-1:0]   stock_d [NUM_COINS];

   logic [NUM_COINS-1:0]    sel_oh;
   logic [TOTAL_BITS-1:0]   sel_val;
   logic                    found;
   logic                    disp_fire;

   // Coin values zero-extended to money width. Indices without a value
   // parameter read as all-ones so they never qualify.
   function automatic logic [TOTAL_BITS-1:0] coin_val(input int idx);
      case (idx)
         0:       coin_val = TOTAL_BITS'(COIN_VAL0);
         1:       coin_val = TOTAL_BITS'(COIN_VAL1);
         2:       coin_val = TOTAL_BITS'(COIN_VAL2);
         default: coin_val = '1;
      endcase
   endfunction

   // Greedy pick: scan from the largest coin down, first fit with stock wins.
   always_comb begin
      sel_oh  = '0;
      sel_val = '0;
      found   = 1'b0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (!found && coin_val(i) <= remaining_q && stock_q[i] != '0) begin
            sel_oh[i] = 1'b1;
            sel_val   = coin_val(i);
            found     = 1'b1;
         end
      end
   end

   // A nonzero remaining with a qualifying coin is the only way to issue one.
   assign disp_fire = (state_q == DISPENSE) && (remaining_q != '0) && found;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         ret_q       <= '0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         residual_q  <= '0;
      end else begin
         ret_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_return_req) begin
                  remaining_q <= i_return_amount;
                  state_q     <= DISPENSE;
               end
            end
            DISPENSE: begin
               if (disp_fire) begin
                  ret_q       <= sel_oh;
                  remaining_q <= remaining_q - sel_val;
               end else begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  short_q    <= (remaining_q != '0);
                  residual_q <= remaining_q;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Per-coin stock counters: insert saturates, insert+dispense cancels.
   for (genvar g = 0; g < NUM_COINS; g++) begin : g_stock
      logic ins, dec;
      assign ins = i_input_coin[g];
      assign dec = disp_fire & sel_oh[g];

      always_comb begin
         stock_d[g] = stock_q[g];
         if (ins && !dec && stock_q[g] != '1)
            stock_d[g] = stock_q[g] + 1'b1;
         else if (dec && !ins)
            stock_d[g] = stock_q[g] - 1'b1;
      end

      always_ff @(posedge clk) begin
         if (reset) stock_q[g] <= STOCK_BITS'(INIT_STOCK);
         else       stock_q[g] <= stock_d[g];
      end

      assign o_stock[g*STOCK_BITS +: STOCK_BITS] = stock_q[g];
   end

   assign o_return_coin = ret_q;
   assign o_busy        = (state_q != IDLE);
   assign o_done        = done_q;
   assign o_short       = short_q;
   assign o_residual    = residual_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy order, shortfall, zero amount,
// insert/dispense interaction, saturation and mid-payout reset.
module tb_change_dispenser;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_return_req;
   logic [30:0] i_return_amount;
   logic [2:0]  i_input_coin;
   logic [2:0]  o_return_coin;
   logic        o_busy;
   logic        o_done;
   logic        o_short;
   logic [30:0] o_residual;
   logic [23:0] o_stock;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk            (clk),
      .reset          (reset),
      .i_return_req   (i_return_req),
      .i_return_amount(i_return_amount),
      .i_input_coin   (i_input_coin),
      .o_return_coin  (o_return_coin),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_short        (o_short),
      .o_residual     (o_residual),
      .o_stock        (o_stock)
   );

   // Advance one rising edge and settle; outputs are sampled after this.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) tick();
      checks++;
      if ({o_return_coin, o_busy, o_done, o_short} !== 6'b0 || o_residual !== 31'd0) begin
         failures++;
         $display("FAIL reset_outputs coin=%b busy=%b done=%b short=%b res=%0d want all 0",
                  o_return_coin, o_busy, o_done, o_short, o_residual);
      end
      checks++;
      if (o_stock !== 24'h020202) begin
         failures++;
         $display("FAIL reset_stock got=%h want=020202", o_stock);
      end
   endtask

   task automatic test_exact_1600();
      logic [2:0] exp [3] = '{3'b100, 3'b010, 3'b001};
      do_reset();
      i_return_req = 1'b1; i_return_amount = 31'd1600;
      tick();                                 // E0
      i_return_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (o_return_coin !== exp[k] || o_done !== 1'b0) begin
            failures++;
            $display("FAIL exact_coin%0d coin=%b done=%b want coin=%b done=0",
                     k, o_return_coin, o_done, exp[k]);
         end
      end
      tick();
      checks++;
      if (o_done !== 1'b1 || o_short !== 1'b0 || o_residual !== 31'd0 || o_return_coin !== 3'b0) begin
         failures++;
         $display("FAIL exact_done done=%b short=%b res=%0d coin=%b want 1,0,0,000",
                  o_done, o_short, o_residual, o_return_coin);
      end
      checks++;
      if (o_stock !== 24'h010101) begin
         failures++;
         $display("FAIL exact_stock got=%h want=010101", o_stock);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL exact_idle busy=%b done=%b want 0,0", o_busy, o_done);
      end
   endtask

   task automatic test_short_3500();
      logic [2:0] exp [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
      do_reset();
      i_return_req = 1'b1; i_return_amount = 31'd3500;
      tick();
      i_return_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (o_return_coin !== exp[k] || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL short_coin%0d coin=%b busy=%b want coin=%b busy=1",
                     k, o_return_coin, o_busy, exp[k]);
         end
      end
      tick();
      checks++;
      if (o_done !== 1'b1 || o_short !== 1'b1 || o_residual !== 31'd300 || o_return_coin !== 3'b0) begin
         failures++;
         $display("FAIL short_done done=%b short=%b res=%0d coin=%b want 1,1,300,000",
                  o_done, o_short, o_residual, o_return_coin);
      end
      checks++;
      if (o_stock !== 24'h000000) begin
         failures++;
         $display("FAIL short_stock got=%h want=000000", o_stock);
      end
      tick();
      checks++;
      if (o_residual !== 31'd300 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL short_hold res=%0d done=%b want 300,0", o_residual, o_done);
      end
   endtask

   task automatic test_zero_and_busy_req();
      do_reset();
      i_return_req = 1'b1; i_return_amount = 31'd0;
      tick();                                 // E0
      i_return_req = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL zero_e0 busy=%b done=%b want 1,0", o_busy, o_done);
      end
      tick();                                 // E1
      checks++;
      if (o_done !== 1'b1 || o_short !== 1'b0 || o_return_coin !== 3'b0 || o_residual !== 31'd0) begin
         failures++;
         $display("FAIL zero_done done=%b short=%b coin=%b res=%0d want 1,0,000,0",
                  o_done, o_short, o_return_coin, o_residual);
      end
      i_return_req = 1'b1; i_return_amount = 31'd500;   // arrives in DONE
      tick();                                 // E2
      i_return_req = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL zero_ignore busy=%b done=%b want 0,0", o_busy, o_done);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_return_coin !== 3'b0 || o_stock !== 24'h020202) begin
         failures++;
         $display("FAIL zero_ignore2 busy=%b coin=%b stock=%h want 0,000,020202",
                  o_busy, o_return_coin, o_stock);
      end
   endtask

   task automatic test_insert_and_saturate();
      do_reset();
      i_return_req = 1'b1; i_return_amount = 31'd1600;
      tick();
      i_return_req = 1'b0;
      repeat (5) tick();                      // 3 coins, done, idle
      checks++;
      if (o_stock !== 24'h010101 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL ins_setup stock=%h busy=%b want 010101,0", o_stock, o_busy);
      end
      i_return_req = 1'b1; i_return_amount = 31'd100;
      tick();                                 // E0
      i_return_req = 1'b0;
      i_input_coin = 3'b001;                  // present on the dispense edge
      tick();                                 // E1
      i_input_coin = 3'b000;
      checks++;
      if (o_return_coin !== 3'b001 || o_stock !== 24'h010101) begin
         failures++;
         $display("FAIL ins_net0 coin=%b stock=%h want 001,010101", o_return_coin, o_stock);
      end
      tick();
      checks++;
      if (o_done !== 1'b1 || o_short !== 1'b0) begin
         failures++;
         $display("FAIL ins_done done=%b short=%b want 1,0", o_done, o_short);
      end
      tick();
      i_input_coin = 3'b010;
      repeat (300) tick();
      i_input_coin = 3'b000;
      tick();
      checks++;
      if (o_stock !== 24'h01FF01) begin
         failures++;
         $display("FAIL sat_stock got=%h want=01ff01", o_stock);
      end
   endtask

   task automatic test_reset_mid_payout();
      bit saw_done = 1'b0;
      do_reset();
      i_return_req = 1'b1; i_return_amount = 31'd1600;
      tick();
      i_return_req = 1'b0;
      tick();                                 // first coin
      checks++;
      if (o_return_coin !== 3'b100) begin
         failures++;
         $display("FAIL mid_first coin=%b want=100", o_return_coin);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (o_return_coin !== 3'b0 || o_stock !== 24'h020202 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset coin=%b stock=%h busy=%b done=%b want 000,020202,0,0",
                  o_return_coin, o_stock, o_busy, o_done);
      end
      repeat (4) begin
         tick();
         if (o_done || o_return_coin != 3'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL mid_abandon activity after reset got=%b want=0", saw_done);
      end
      i_return_req = 1'b1; i_return_amount = 31'd500;
      tick();
      i_return_req = 1'b0;
      tick();
      checks++;
      if (o_return_coin !== 3'b010) begin
         failures++;
         $display("FAIL mid_new_coin coin=%b want=010", o_return_coin);
      end
      tick();
      checks++;
      if (o_done !== 1'b1 || o_short !== 1'b0 || o_residual !== 31'd0 || o_stock !== 24'h020102) begin
         failures++;
         $display("FAIL mid_new_done done=%b short=%b res=%0d stock=%h want 1,0,0,020102",
                  o_done, o_short, o_residual, o_stock);
      end
   endtask

   initial begin
      reset           = 1'b1;
      i_return_req    = 1'b0;
      i_return_amount = '0;
      i_input_coin    = '0;
      test_reset();
      test_exact_1600();
      test_short_3500();
      test_zero_and_busy_req();
      test_insert_and_saturate();
      test_reset_mid_payout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
